// File: rtl/dll_phase_pkg.sv
// Shared types and helpers for the DLL phase sequencer: FSM states, error
// cause codes and the shortest-path direction decision.
package dll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STEP,
    WAIT,
    FIN,
    FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CH  = 2'd1;
  localparam logic [1:0] ERR_LOCK    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // diff is (target - current) mod 2^phase_w; exactly half range resolves to increment.
  function automatic logic shortest_inc(input logic [31:0] diff, input int phase_w);
    logic [31:0] half;
    half = 32'd1 << (phase_w - 1);
    return (diff != 32'd0) && (diff <= half);
  endfunction

endpackage

// File: rtl/dll_phase_track.sv
// One channel's tracked DLL phase: a wrapping up/down counter.
module dll_phase_track #(
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [PHASE_W-1:0] phase
);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (inc) begin
      phase <= phase + PHASE_W'(1);
    end else if (dec) begin
      phase <= phase - PHASE_W'(1);
    end
  end

endmodule

// File: rtl/dll_phase_seq.sv
// Sequencer that walks one DLL channel at a time to a requested absolute phase,
// one acknowledged step at a time along the shortest wrap-around path.
module dll_phase_seq
  import dll_phase_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int PHASE_W     = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int CH_W        = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic [CH_W-1:0]             REQ_CH,
  input  logic [PHASE_W-1:0]          REQ_PHASE,
  output logic                        DONE,
  output logic                        ERR,
  output logic [1:0]                  ERR_CODE,
  output logic [NUM_CH*PHASE_W-1:0]   CUR_PHASE,
  output logic [NUM_CH-1:0]           DLL_DIR,
  output logic [NUM_CH-1:0]           DLL_CLK_MOVE,
  input  logic [NUM_CH-1:0]           DLL_CLK_MOVE_DONE,
  input  logic [NUM_CH-1:0]           DLL_LOCK
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t state, nxt;

  logic [CH_W-1:0]    req_ch_p0;
  logic [PHASE_W-1:0] req_phase_p0;
  logic               dir_p0;
  logic [1:0]         err_code_p0;
  logic [CNT_W-1:0]   wait_cnt;

  logic [PHASE_W-1:0] phase_lane [NUM_CH];
  logic [NUM_CH-1:0]  sel, inc, dec;
  logic [PHASE_W-1:0] cur_sel, diff;
  logic               lock_sel, ack_sel, ch_ok, dir_calc;
  logic               dir_load, err_set;
  logic [1:0]         err_nxt;

  // Channel decode doubles as the range check: an index with no matching lane selects nothing.
  always_comb begin
    sel      = '0;
    cur_sel  = '0;
    lock_sel = 1'b0;
    ack_sel  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ch_p0 == CH_W'(i)) begin
        sel[i]   = 1'b1;
        cur_sel  = phase_lane[i];
        lock_sel = DLL_LOCK[i];
        ack_sel  = DLL_CLK_MOVE_DONE[i];
      end
    end
  end

  assign ch_ok    = |sel;
  assign diff     = req_phase_p0 - cur_sel;
  assign dir_calc = shortest_inc(32'(diff), PHASE_W);

  always_comb begin
    nxt      = state;
    dir_load = 1'b0;
    err_set  = 1'b0;
    err_nxt  = err_code_p0;
    inc      = '0;
    dec      = '0;
    case (state)
      IDLE:  if (REQ_VALID) nxt = CHECK;
      CHECK: begin
        if (!ch_ok) begin
          nxt = FAIL; err_set = 1'b1; err_nxt = ERR_BAD_CH;
        end else if (!lock_sel) begin
          nxt = FAIL; err_set = 1'b1; err_nxt = ERR_LOCK;
        end else if (diff == '0) begin
          nxt = FIN;
        end else begin
          nxt = STEP; dir_load = 1'b1;
        end
      end
      STEP:  nxt = WAIT;
      WAIT: begin
        if (!lock_sel) begin
          nxt = FAIL; err_set = 1'b1; err_nxt = ERR_LOCK;
        end else if (ack_sel) begin
          nxt = CHECK;
          inc = sel & {NUM_CH{dir_p0}};
          dec = sel & {NUM_CH{~dir_p0}};
        end else if (wait_cnt == TMO_LAST) begin
          nxt = FAIL; err_set = 1'b1; err_nxt = ERR_TIMEOUT;
        end
      end
      FIN:     nxt = IDLE;
      FAIL:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      dir_p0      <= 1'b0;
      err_code_p0 <= ERR_NONE;
      wait_cnt    <= '0;
    end else begin
      state <= nxt;
      if (dir_load) dir_p0 <= dir_calc;
      if (err_set)  err_code_p0 <= err_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
    end
  end

  // Request capture stage: data only, loaded on handshake.
  always_ff @(posedge CLK) begin
    if (state == IDLE && REQ_VALID) begin
      req_ch_p0    <= REQ_CH;
      req_phase_p0 <= REQ_PHASE;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    dll_phase_track #(.PHASE_W(PHASE_W)) u_track (
      .clk   (CLK),
      .rst   (RESET),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .phase (phase_lane[g])
    );
    assign CUR_PHASE[g*PHASE_W +: PHASE_W] = phase_lane[g];
  end

  assign REQ_READY    = (state == IDLE) && !RESET;
  assign DONE         = (state == FIN);
  assign ERR          = (state == FAIL);
  assign ERR_CODE     = err_code_p0;
  assign DLL_CLK_MOVE = (state == STEP) ? sel : '0;
  assign DLL_DIR      = ((state == STEP || state == WAIT) && dir_p0) ? sel : '0;

endmodule
